// File: rtl/gshare_direction_predictor.sv
// rtl/gshare_direction_predictor.sv - gshare direction predictor combining registered BTB hit/target with a PHT of 2-bit counters
module gshare_direction_predictor #(
   parameter int         HIST_BITS    = 5,
   parameter logic [1:0] COUNTER_INIT = 2'b01
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          pc_in,
   input  logic                 stall,
   input  logic                 advance,
   input  logic                 btb_hit,
   input  logic [31:0]          btb_target,
   input  logic                 update_valid,
   input  logic [31:0]          update_pc,
   input  logic                 update_taken,
   input  logic [HIST_BITS-1:0] update_ghr,
   input  logic                 mispredict,
   output logic                 pred_taken,
   output logic [31:0]          pred_next_pc,
   output logic [HIST_BITS-1:0] pred_ghr,
   output logic [HIST_BITS-1:0] ghr
);

   localparam int ENTRIES = 2 ** HIST_BITS;

   logic [1:0]           r_pht [ENTRIES];
   logic [31:0]          r_pc;
   logic [1:0]           r_ctr;
   logic [HIST_BITS-1:0] r_ghr;
   logic [HIST_BITS-1:0] r_ghr_snap;

   logic [HIST_BITS-1:0] w_idx_f;
   logic [HIST_BITS-1:0] w_idx_u;
   logic                 w_pred_taken;
   logic                 w_unused_bits;

   assign w_idx_f = pc_in[HIST_BITS+1:2] ^ r_ghr;
   assign w_idx_u = update_pc[HIST_BITS+1:2] ^ update_ghr;

   // Address bits outside the index field never reach the tables.
   assign w_unused_bits = &{1'b0, pc_in[31:HIST_BITS+2], pc_in[1:0],
                            update_pc[31:HIST_BITS+2], update_pc[1:0]};

   // Train the pattern-history table from EX resolution with saturating counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_pht[i] <= COUNTER_INIT;
         end
      end else if (update_valid) begin
         if (update_taken) begin
            if (r_pht[w_idx_u] != 2'b11) begin
               r_pht[w_idx_u] <= r_pht[w_idx_u] + 2'd1;
            end
         end else begin
            if (r_pht[w_idx_u] != 2'b00) begin
               r_pht[w_idx_u] <= r_pht[w_idx_u] - 2'd1;
            end
         end
      end
   end

   // Fetch-side lookup registers line up with the BTB's registered outputs; the read sees the pre-training value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc       <= 32'd0;
         r_ctr      <= 2'b00;
         r_ghr_snap <= '0;
      end else if (!stall) begin
         r_pc       <= pc_in;
         r_ctr      <= r_pht[w_idx_f];
         r_ghr_snap <= r_ghr;
      end
   end

   // Speculative history shifts on consumed BTB hits; an EX repair takes priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ghr <= '0;
      end else if (mispredict) begin
         r_ghr <= {update_ghr[HIST_BITS-2:0], update_taken};
      end else if (advance && btb_hit) begin
         r_ghr <= {r_ghr[HIST_BITS-2:0], w_pred_taken};
      end
   end

   assign w_pred_taken = btb_hit & r_ctr[1];

   // Prediction outputs are combinational from the lookup registers and the BTB result.
   always_comb begin
      pred_taken   = w_pred_taken;
      pred_next_pc = w_pred_taken ? btb_target : (r_pc + 32'd4);
      pred_ghr     = r_ghr_snap;
      ghr          = r_ghr;
   end

endmodule

// File: tb/tb_gshare_direction_predictor.sv
// tb/tb_gshare_direction_predictor.sv - randomized self-checking bench for gshare_direction_predictor
module tb_gshare_direction_predictor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        stall;
   logic        advance;
   logic        btb_hit;
   logic [31:0] btb_target;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [4:0]  update_ghr;
   logic        mispredict;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic [4:0]  pred_ghr;
   logic [4:0]  ghr;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   // reference model state
   int          pht [32];
   logic [31:0] m_pc   = 32'd0;
   int          m_ctr  = 0;
   logic [4:0]  m_ghr  = 5'd0;
   logic [4:0]  m_snap = 5'd0;

   int          fi, ui, old_ctr;
   logic        tk;
   logic [4:0]  g_old;
   logic        exp_t;
   logic [31:0] exp_npc;

   gshare_direction_predictor #(.HIST_BITS(5), .COUNTER_INIT(2'b01)) dut (
      .clk(clk), .reset(rst_n), .pc_in(pc_in), .stall(stall), .advance(advance),
      .btb_hit(btb_hit), .btb_target(btb_target), .update_valid(update_valid),
      .update_pc(update_pc), .update_taken(update_taken), .update_ghr(update_ghr),
      .mispredict(mispredict), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
      .pred_ghr(pred_ghr), .ghr(ghr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // model: asynchronous reset
   always @(negedge rst_n) begin
      for (int i = 0; i < 32; i++) pht[i] = 1;
      m_pc = 32'd0; m_ctr = 0; m_ghr = 5'd0; m_snap = 5'd0;
   end

   // model: behaviour at each rising edge, all decisions from pre-edge values
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         fi      = int'(((pc_in >> 2) ^ 32'(m_ghr)) % 32);
         ui      = int'(((update_pc >> 2) ^ 32'(update_ghr)) % 32);
         tk      = btb_hit && (m_ctr >= 2);
         old_ctr = pht[fi];
         g_old   = m_ghr;
         if (!stall) begin
            m_pc = pc_in; m_ctr = old_ctr; m_snap = g_old;
         end
         if (mispredict) m_ghr = {update_ghr[3:0], update_taken};
         else if (advance && btb_hit) m_ghr = {g_old[3:0], tk};
         if (update_valid) begin
            if (update_taken) pht[ui] = (pht[ui] < 3) ? pht[ui] + 1 : 3;
            else              pht[ui] = (pht[ui] > 0) ? pht[ui] - 1 : 0;
         end
      end
   end

   // compare process: outputs against the model every cycle
   always @(negedge clk) begin
      if (cmp_en) begin
         exp_t   = btb_hit && (m_ctr >= 2);
         exp_npc = exp_t ? btb_target : m_pc + 32'd4;
         chk("cyc_pred_taken", 32'(pred_taken), 32'(exp_t));
         chk("cyc_pred_next_pc", pred_next_pc, exp_npc);
         chk("cyc_pred_ghr", 32'(pred_ghr), 32'(m_snap));
         chk("cyc_ghr", 32'(ghr), 32'(m_ghr));
      end
   end

   task automatic upd(input logic [31:0] pc, input logic [4:0] g, input logic t, input int n);
      update_valid = 1'b1; update_pc = pc; update_ghr = g; update_taken = t;
      repeat (n) cyc();
      update_valid = 1'b0;
   endtask

   initial begin
      pc_in = 0; stall = 0; advance = 0; btb_hit = 0; btb_target = 0;
      update_valid = 0; update_pc = 0; update_taken = 0; update_ghr = 0; mispredict = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      cmp_en = 1'b1;
      repeat (3) cyc();
      chk("reset_pred_taken", 32'(pred_taken), 32'd0);
      chk("reset_next_pc", pred_next_pc, 32'h4);
      chk("reset_ghr", 32'(ghr), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) chk("reset_pht", 32'(dut.r_pht[i]), 32'd1);
      cyc();
      chk("post_reset_next_pc", pred_next_pc, 32'h4);

      // train and predict
      upd(32'h40, 5'd0, 1'b1, 2);
      chk("train_pht16", 32'(dut.r_pht[16]), 32'd3);
      chk("model_pht16", 32'(pht[16]), 32'd3);
      pc_in = 32'h40;
      cyc();
      btb_hit = 1'b1; btb_target = 32'h100;
      #1;
      chk("train_taken", 32'(pred_taken), 32'd1);
      chk("train_next_pc", pred_next_pc, 32'h100);
      chk("train_pred_ghr", 32'(pred_ghr), 32'd0);
      btb_hit = 1'b0;

      // saturation
      upd(32'h40, 5'd0, 1'b1, 2);
      chk("sat_high", 32'(dut.r_pht[16]), 32'd3);
      upd(32'h40, 5'd0, 1'b0, 4);
      chk("sat_zero", 32'(dut.r_pht[16]), 32'd0);
      upd(32'h40, 5'd0, 1'b0, 1);
      chk("sat_low", 32'(dut.r_pht[16]), 32'd0);
      chk("model_sat_low", 32'(pht[16]), 32'd0);
      cyc();
      btb_hit = 1'b1;
      #1;
      chk("sat_taken", 32'(pred_taken), 32'd0);
      chk("sat_next_pc", pred_next_pc, 32'h44);
      btb_hit = 1'b0;

      // speculative shift
      upd(32'h40, 5'd0, 1'b1, 2);
      mispredict = 1'b1; update_ghr = 5'd0; update_taken = 1'b1;
      cyc();
      mispredict = 1'b0; pc_in = 32'h44;
      chk("shift_setup_ghr", 32'(ghr), 32'd1);
      cyc();
      btb_hit = 1'b1; advance = 1'b1; btb_target = 32'h200;
      #1;
      chk("shift_taken", 32'(pred_taken), 32'd1);
      chk("shift_pred_ghr", 32'(pred_ghr), 32'd1);
      cyc();
      chk("shift_ghr", 32'(ghr), 32'b00011);
      btb_hit = 1'b0; pc_in = 32'h4C;
      cyc();
      chk("noshift_ghr", 32'(ghr), 32'b00011);

      // repair priority
      btb_hit = 1'b1; mispredict = 1'b1; update_ghr = 5'b10101; update_taken = 1'b0;
      #1;
      chk("repair_taken", 32'(pred_taken), 32'd1);
      cyc();
      chk("repair_ghr", 32'(ghr), 32'b01010);
      mispredict = 1'b0; advance = 1'b0; btb_hit = 1'b0;

      // wrap of pc+4
      pc_in = 32'hFFFF_FFFC;
      cyc();
      chk("wrap_next_pc", pred_next_pc, 32'h0);

      // stall hold
      pc_in = 32'h40;
      cyc();
      chk("stall_pre", pred_next_pc, 32'h44);
      stall = 1'b1; pc_in = 32'h80;
      cyc(); cyc();
      chk("stall_hold", pred_next_pc, 32'h44);
      stall = 1'b0;

      // asynchronous reset between edges
      btb_hit = 1'b1; btb_target = 32'h300;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_taken", 32'(pred_taken), 32'd0);
      chk("async_ghr", 32'(ghr), 32'd0);
      chk("async_next_pc", pred_next_pc, 32'h4);
      chk("async_pht16", 32'(dut.r_pht[16]), 32'd1);
      #3 rst_n = 1'b1;
      btb_hit = 1'b0;

      // randomized phase
      for (int n = 0; n < 3000; n++) begin
         cyc();
         pc_in        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'h0000_00FC);
         stall        = ($urandom_range(0, 3) == 0);
         advance      = $urandom_range(0, 1) == 1;
         btb_hit      = $urandom_range(0, 1) == 1;
         btb_target   = $urandom() & 32'hFFFF_FFFC;
         update_valid = $urandom_range(0, 1) == 1;
         update_pc    = $urandom() & 32'h0000_00FC;
         update_taken = ($urandom_range(0, 2) != 0);
         update_ghr   = 5'($urandom());
         mispredict   = ($urandom_range(0, 7) == 0);
      end
      cyc();
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
